// File: rtl/mmio_cmd_master.sv
// mmio_cmd_master: byte-stream command bridge acting as an FPro MMIO initiator.
// Accepts 'W'/'R' frames from a byte source, runs one bus transaction per frame,
// and returns 'K', four read-data bytes, or '?' for an unknown opcode.
module mmio_cmd_master #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mmio_cs,
  output logic        mmio_wr,
  output logic        mmio_rd,
  output logic [20:0] mmio_addr,
  output logic [31:0] mmio_wr_data,
  input  logic [31:0] mmio_rd_data
);

  localparam int unsigned GW = $clog2(TIMEOUT);

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_WR,
    S_BUS_RD,
    S_ERR,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          is_rd_q, is_rd_d;
  logic [20:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    txd_q, txd_d;
  logic          txv_q, txv_d;
  logic [23:0]   txsh_q, txsh_d;
  logic [2:0]    left_q, left_d;

  logic rx_fire;
  logic tx_fire;

  // Handshake and bus strobes are pure decodes of the current state.
  always_comb begin
    rx_ready = (state_q == S_IDLE) || (state_q == S_ADDR) || (state_q == S_DATA);
    mmio_cs  = (state_q == S_BUS_WR) || (state_q == S_BUS_RD);
    mmio_wr  = (state_q == S_BUS_WR);
    mmio_rd  = (state_q == S_BUS_RD);
  end

  assign rx_fire      = rx_valid && rx_ready;
  assign tx_fire      = txv_q && tx_ready;
  assign tx_data      = txd_q;
  assign tx_valid     = txv_q;
  assign mmio_addr    = addr_q;
  assign mmio_wr_data = wdata_q;

  // Next-state logic: frame parsing, bus cycle, response sequencing, gap timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    gap_d   = gap_q;
    txd_d   = txd_q;
    txv_d   = txv_q;
    txsh_d  = txsh_q;
    left_d  = left_q;

    unique case (state_q)
      S_IDLE: begin
        gap_d = '0;
        if (rx_fire) begin
          cnt_d = '0;
          if (rx_data == OP_WR) begin
            is_rd_d = 1'b0;
            state_d = S_ADDR;
          end else if (rx_data == OP_RD) begin
            is_rd_d = 1'b1;
            state_d = S_ADDR;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_ADDR: begin
        if (rx_fire) begin
          // Shifting into a 21-bit register drops byte 1 bits [7:5] on its own.
          addr_d = {addr_q[12:0], rx_data};
          gap_d  = '0;
          if (cnt_q == 2'd2) begin
            cnt_d   = '0;
            state_d = is_rd_q ? S_BUS_RD : S_DATA;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (gap_q == GW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      S_DATA: begin
        if (rx_fire) begin
          wdata_d = {wdata_q[23:0], rx_data};
          gap_d   = '0;
          if (cnt_q == 2'd3) begin
            cnt_d   = '0;
            state_d = S_BUS_WR;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (gap_q == GW'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      S_BUS_WR: begin
        txd_d   = RSP_ACK;
        txv_d   = 1'b1;
        left_d  = 3'd1;
        state_d = S_RESP;
      end

      S_BUS_RD: begin
        txd_d   = mmio_rd_data[31:24];
        txsh_d  = mmio_rd_data[23:0];
        txv_d   = 1'b1;
        left_d  = 3'd4;
        state_d = S_RESP;
      end

      S_ERR: begin
        // tx_valid is raised one cycle later in RESP, giving the error reply
        // its extra cycle of latency relative to the bus paths.
        txd_d   = RSP_ERR;
        left_d  = 3'd1;
        state_d = S_RESP;
      end

      S_RESP: begin
        if (!txv_q) begin
          txv_d = 1'b1;
        end else if (tx_fire) begin
          if (left_q == 3'd1) begin
            txv_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            txd_d  = txsh_q[23:16];
            txsh_d = {txsh_q[15:0], 8'h00};
            left_d = left_q - 3'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gap_q   <= '0;
      txd_q   <= '0;
      txv_q   <= 1'b0;
      txsh_q  <= '0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      gap_q   <= gap_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
      txsh_q  <= txsh_d;
      left_q  <= left_d;
    end
  end

endmodule

// File: tb/tb_mmio_cmd_master.sv
// Directed self-checking bench for mmio_cmd_master (TIMEOUT = 16).
module tb_mmio_cmd_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        mmio_cs, mmio_wr, mmio_rd;
  logic [20:0] mmio_addr;
  logic [31:0] mmio_wr_data;
  logic [31:0] rd_value = 32'h12345678;

  int checks = 0;
  int failures = 0;

  int strobe_cnt = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int bad_strobe = 0;
  logic [20:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [7:0]  txq [$];

  mmio_cmd_master #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .mmio_cs      (mmio_cs),
    .mmio_wr      (mmio_wr),
    .mmio_rd      (mmio_rd),
    .mmio_addr    (mmio_addr),
    .mmio_wr_data (mmio_wr_data),
    .mmio_rd_data (rd_value)
  );

  always #5 clk = ~clk;

  // Bus and response observer: records strobes and transferred tx bytes.
  always @(posedge clk) begin
    if (!reset) begin
      if ((mmio_wr || mmio_rd) && !mmio_cs) bad_strobe++;
      if (mmio_wr && mmio_rd) bad_strobe++;
      if (mmio_cs) begin
        strobe_cnt++;
        last_addr = mmio_addr;
        last_wdata = mmio_wr_data;
        if (mmio_wr) wr_cnt++;
        if (mmio_rd) rd_cnt++;
      end
      if (tx_valid && tx_ready) txq.push_back(tx_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_data = b;
    rx_valid = 1'b1;
    k = 0;
    while (!rx_ready && k < 100) begin
      step();
      k++;
    end
    checks++;
    if (k >= 100) begin
      failures++;
      $display("FAIL send_byte_timeout byte=%02h rx_ready never rose", b);
    end
    step();
    rx_valid = 1'b0;
  endtask

  task automatic recv_bytes(input int n);
    int k;
    tx_ready = 1'b1;
    k = 0;
    while (txq.size() < n && k < 200) begin
      step();
      k++;
    end
    tx_ready = 1'b0;
    checks++;
    if (txq.size() != n) begin
      failures++;
      $display("FAIL recv_count got=%0d want=%0d", txq.size(), n);
    end
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL recv_idle tx_valid=%b rx_ready=%b want 0/1", tx_valid, rx_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({mmio_cs, mmio_wr, mmio_rd, tx_valid} !== 4'b0 || mmio_addr !== 21'h0 ||
        mmio_wr_data !== 32'h0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_values cs/wr/rd/txv=%b%b%b%b addr=%h wd=%h txd=%h want all zero",
               mmio_cs, mmio_wr, mmio_rd, tx_valid, mmio_addr, mmio_wr_data, tx_data);
    end
    reset = 1'b0;
    step();
    checks++;
    if (rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_rx_ready got=%b want=1", rx_ready);
    end
  endtask

  task automatic test_write();
    logic [7:0] fr [8];
    int s0;
    fr = '{8'h57, 8'h00, 8'h00, 8'h20, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    s0 = wr_cnt;
    txq.delete();
    foreach (fr[i]) send_byte(fr[i]);
    checks++;
    if (mmio_cs !== 1'b1 || mmio_wr !== 1'b1 || mmio_rd !== 1'b0 ||
        mmio_addr !== 21'h000020 || mmio_wr_data !== 32'hDEADBEEF || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL write_strobe cs=%b wr=%b rd=%b addr=%h wd=%h txv=%b want 1 1 0 000020 deadbeef 0",
               mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, tx_valid);
    end
    step();
    checks++;
    if (mmio_cs !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      failures++;
      $display("FAIL write_ack cs=%b txv=%b txd=%h want 0 1 4b", mmio_cs, tx_valid, tx_data);
    end
    recv_bytes(1);
    checks++;
    if (txq.size() != 1 || txq[0] !== 8'h4B || wr_cnt != s0 + 1) begin
      failures++;
      $display("FAIL write_resp bytes=%0d wr_strobes=%0d want 1 byte 4b, %0d strobes",
               txq.size(), wr_cnt - s0, 1);
    end
  endtask

  task automatic test_read();
    logic [7:0] exp [4];
    int s0;
    exp = '{8'h12, 8'h34, 8'h56, 8'h78};
    rd_value = 32'h12345678;
    s0 = rd_cnt;
    txq.delete();
    send_byte(8'h52); send_byte(8'h1F); send_byte(8'hFF); send_byte(8'hFF);
    checks++;
    if (mmio_cs !== 1'b1 || mmio_rd !== 1'b1 || mmio_wr !== 1'b0 || mmio_addr !== 21'h1FFFFF) begin
      failures++;
      $display("FAIL read_strobe cs=%b rd=%b wr=%b addr=%h want 1 1 0 1fffff",
               mmio_cs, mmio_rd, mmio_wr, mmio_addr);
    end
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h12) begin
      failures++;
      $display("FAIL read_first txv=%b txd=%h want 1 12", tx_valid, tx_data);
    end
    recv_bytes(4);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txq.size() <= i || txq[i] !== exp[i]) begin
        failures++;
        $display("FAIL read_byte%0d got=%h want=%h", i, (txq.size() > i) ? txq[i] : 8'hxx, exp[i]);
      end
    end
    checks++;
    if (rd_cnt != s0 + 1) begin
      failures++;
      $display("FAIL read_strobe_count got=%0d want=1", rd_cnt - s0);
    end
  endtask

  task automatic test_error();
    logic [7:0] fr [8];
    int s0;
    fr = '{8'h57, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    s0 = strobe_cnt;
    txq.delete();
    send_byte(8'h00);
    step();
    checks++;
    if (tx_valid !== 1'b0 || mmio_cs !== 1'b0) begin
      failures++;
      $display("FAIL err_early txv=%b cs=%b want 0 0", tx_valid, mmio_cs);
    end
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h3F) begin
      failures++;
      $display("FAIL err_resp txv=%b txd=%h want 1 3f", tx_valid, tx_data);
    end
    recv_bytes(1);
    checks++;
    if (strobe_cnt != s0 || txq.size() != 1 || txq[0] !== 8'h3F) begin
      failures++;
      $display("FAIL err_nostrobe strobes=%0d bytes=%0d want 0 strobes, 1 byte 3f",
               strobe_cnt - s0, txq.size());
    end
    txq.delete();
    foreach (fr[i]) send_byte(fr[i]);
    recv_bytes(1);
    checks++;
    if (wr_cnt == 0 || strobe_cnt != s0 + 1 || last_addr !== 21'h000100 ||
        last_wdata !== 32'h11223344 || txq.size() != 1 || txq[0] !== 8'h4B) begin
      failures++;
      $display("FAIL err_then_write strobes=%0d addr=%h wd=%h want 1 000100 11223344 ack",
               strobe_cnt - s0, last_addr, last_wdata);
    end
  endtask

  task automatic test_timeout();
    int s0;
    s0 = strobe_cnt;
    txq.delete();
    send_byte(8'h57); send_byte(8'h00);
    repeat (20) step();
    checks++;
    if (strobe_cnt != s0 || txq.size() != 0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_drop strobes=%0d bytes=%0d txv=%b want 0 0 0",
               strobe_cnt - s0, txq.size(), tx_valid);
    end
    rd_value = 32'hCAFEF00D;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
    recv_bytes(4);
    checks++;
    if (rd_cnt == 0 || strobe_cnt != s0 + 1 || last_addr !== 21'h000004 || txq.size() != 4 ||
        txq[0] !== 8'hCA || txq[3] !== 8'h0D) begin
      failures++;
      $display("FAIL timeout_then_read strobes=%0d addr=%h bytes=%0d want 1 000004 4",
               strobe_cnt - s0, last_addr, txq.size());
    end
    // A byte arriving after 15 idle cycles is still within the frame.
    txq.delete();
    rd_value = 32'h0BADBEEF;
    send_byte(8'h52);
    repeat (15) step();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
    recv_bytes(4);
    checks++;
    if (strobe_cnt != s0 + 2 || last_addr !== 21'h000008 || txq.size() != 4 || txq[0] !== 8'h0B) begin
      failures++;
      $display("FAIL timeout_edge strobes=%0d addr=%h bytes=%0d want 2 000008 4",
               strobe_cnt - s0, last_addr, txq.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [4];
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    rd_value = 32'hA1B2C3D4;
    txq.delete();
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    step();
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 10; c++) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== exp[i] || rx_ready !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold byte%0d cyc%0d txv=%b txd=%h rx_ready=%b want 1 %h 0",
                   i, c, tx_valid, tx_data, rx_ready, exp[i]);
        end
        step();
      end
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
    end
    checks++;
    if (tx_valid !== 1'b0 || txq.size() != 4) begin
      failures++;
      $display("FAIL stall_done txv=%b bytes=%0d want 0 4", tx_valid, txq.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (txq.size() <= i || txq[i] !== exp[i]) begin
        failures++;
        $display("FAIL stall_byte%0d got=%h want=%h", i, (txq.size() > i) ? txq[i] : 8'hxx, exp[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int s0;
    s0 = strobe_cnt;
    txq.delete();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00); send_byte(8'h40); send_byte(8'hAA);
    reset = 1'b1;
    step();
    checks++;
    if ({mmio_cs, mmio_wr, mmio_rd, tx_valid} !== 4'b0 || mmio_addr !== 21'h0 ||
        mmio_wr_data !== 32'h0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset addr=%h wd=%h txv=%b txd=%h want all zero",
               mmio_addr, mmio_wr_data, tx_valid, tx_data);
    end
    reset = 1'b0;
    step();
    repeat (5) step();
    checks++;
    if (strobe_cnt != s0 || txq.size() != 0 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL midframe_after strobes=%0d bytes=%0d rx_ready=%b want 0 0 1",
               strobe_cnt - s0, txq.size(), rx_ready);
    end
    rd_value = 32'h11223344;
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00); send_byte(8'h50);
    step();
    tx_ready = 1'b1;
    step();
    tx_ready = 1'b0;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h22) begin
      failures++;
      $display("FAIL midresp_second txv=%b txd=%h want 1 22", tx_valid, tx_data);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if ({mmio_cs, mmio_wr, mmio_rd, tx_valid} !== 4'b0 || mmio_addr !== 21'h0 ||
        mmio_wr_data !== 32'h0 || tx_data !== 8'h00) begin
      failures++;
      $display("FAIL midresp_reset addr=%h wd=%h txv=%b txd=%h want all zero",
               mmio_addr, mmio_wr_data, tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    repeat (10) step();
    tx_ready = 1'b0;
    checks++;
    if (txq.size() != 1 || txq[0] !== 8'h11 || tx_valid !== 1'b0 || strobe_cnt != s0 + 1) begin
      failures++;
      $display("FAIL midresp_after bytes=%0d txv=%b strobes=%0d want 1 0 1",
               txq.size(), tx_valid, strobe_cnt - s0);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_timeout();
    test_backpressure();
    test_mid_reset();
    checks++;
    if (bad_strobe != 0) begin
      failures++;
      $display("FAIL strobe_outside_cs got=%0d want=0", bad_strobe);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1);
  end

endmodule
